battle_sequencer: RTL

BATTLE_SEQUENCER -- requirements
Module: battle_sequencer

---
 rtl/battle_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/battle_sequencer.sv
// -----------------------------------------------------------------------------
// battle_sequencer
//
// Turn sequencer for a simple battle game. It walks the phases
// IDLE -> MENU -> ATTACK -> ENEMY -> MENU ... until one side reaches zero hit
// points, then parks in WIN or LOSE until the player restarts.
//
// Handshake: every *_finished_in input is a single-cycle, valid-only pulse
// (there is no ready). It is acted on only in its own phase, and its damage
// value is sampled in the same cycle. Pulses in any other phase are dropped.
//
// Parameters
//   PLAYER_HP_INIT  player hit points after reset or restart
//   ENEMY_HP_INIT   enemy hit points after reset or restart
//   PHASE_TIMEOUT   cycles an ATTACK or ENEMY phase may last before it is
//                   ended with zero damage
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   start_in            level start/restart request, acted on at its rising edge
//   menu_finished_in    pulse: menu done, move to ATTACK
//   attack_finished_in  pulse: player attack done
//   attack_damage_in    damage to the enemy, valid with attack_finished_in
//   enemy_finished_in   pulse: enemy turn done
//   player_damage_in    damage to the player, valid with enemy_finished_in
//   state_out           registered phase code (also the FSM debug view)
//   player_hp_out       current player hit points
//   enemy_hp_out        current enemy hit points
//   win_out             high while in WIN
//   lose_out            high while in LOSE
// -----------------------------------------------------------------------------
module battle_sequencer #(
    parameter logic [7:0]  PLAYER_HP_INIT = 8'd20,
    parameter logic [7:0]  ENEMY_HP_INIT  = 8'd100,
    parameter logic [31:0] PHASE_TIMEOUT  = 32'd32_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_in,
    input  logic       menu_finished_in,
    input  logic       attack_finished_in,
    input  logic [7:0] attack_damage_in,
    input  logic       enemy_finished_in,
    input  logic [7:0] player_damage_in,
    output logic [3:0] state_out,
    output logic [7:0] player_hp_out,
    output logic [7:0] enemy_hp_out,
    output logic       win_out,
    output logic       lose_out
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b1010,
        ST_MENU   = 4'b0000,
        ST_ATTACK = 4'b0001,
        ST_ENEMY  = 4'b0010,
        ST_WIN    = 4'b1100,
        ST_LOSE   = 4'b1101
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  player_hp_q, player_hp_d;
    logic [7:0]  enemy_hp_q, enemy_hp_d;
    logic [31:0] counter_q, counter_d;
    // start_low_q: start_in was seen low on the previous cycle since reset.
    // Cleared by reset so a start_in held high through reset release is
    // not mistaken for a fresh rising edge.
    logic        start_low_q, start_low_d;
    // restart_q: IDLE was entered from WIN/LOSE, so advance to MENU
    // automatically instead of waiting for another start edge.
    logic        restart_q, restart_d;

    logic        start_edge;
    logic        timeout;
    logic [7:0]  enemy_hp_hit;
    logic [7:0]  player_hp_hit;

    assign start_edge = start_in & start_low_q;
    assign timeout    = (counter_q == (PHASE_TIMEOUT - 32'd1));

    // Saturating subtraction: never wraps below zero.
    assign enemy_hp_hit  = (enemy_hp_q  > attack_damage_in) ? (enemy_hp_q  - attack_damage_in) : 8'd0;
    assign player_hp_hit = (player_hp_q > player_damage_in) ? (player_hp_q - player_damage_in) : 8'd0;

    always_comb begin
        state_d     = state_q;
        player_hp_d = player_hp_q;
        enemy_hp_d  = enemy_hp_q;
        restart_d   = restart_q;
        start_low_d = ~start_in;

        case (state_q)
            ST_IDLE: begin
                if (restart_q || start_edge) begin
                    state_d   = ST_MENU;
                    restart_d = 1'b0;
                end
            end
            ST_MENU: begin
                if (menu_finished_in) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                // A real finish pulse takes priority over a coincident timeout.
                if (attack_finished_in) begin
                    enemy_hp_d = enemy_hp_hit;
                    state_d    = (enemy_hp_hit == 8'd0) ? ST_WIN : ST_ENEMY;
                end else if (timeout) begin
                    state_d = ST_ENEMY;
                end
            end
            ST_ENEMY: begin
                if (enemy_finished_in) begin
                    player_hp_d = player_hp_hit;
                    state_d     = (player_hp_hit == 8'd0) ? ST_LOSE : ST_MENU;
                end else if (timeout) begin
                    state_d = ST_MENU;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (start_edge) begin
                    state_d     = ST_IDLE;
                    player_hp_d = PLAYER_HP_INIT;
                    enemy_hp_d  = ENEMY_HP_INIT;
                    restart_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase counter runs only in ATTACK/ENEMY and restarts on every change.
    always_comb begin
        counter_d = 32'd0;
        if ((state_d == state_q) && ((state_q == ST_ATTACK) || (state_q == ST_ENEMY))) begin
            counter_d = counter_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            player_hp_q <= PLAYER_HP_INIT;
            enemy_hp_q  <= ENEMY_HP_INIT;
            counter_q   <= 32'd0;
            start_low_q <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            player_hp_q <= player_hp_d;
            enemy_hp_q  <= enemy_hp_d;
            counter_q   <= counter_d;
            start_low_q <= start_low_d;
            restart_q   <= restart_d;
        end
    end

    assign state_out     = state_q;
    assign player_hp_out = player_hp_q;
    assign enemy_hp_out  = enemy_hp_q;
    assign win_out       = (state_q == ST_WIN);
    assign lose_out      = (state_q == ST_LOSE);

endmodule
